// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: synchronised rxd, mid-bit sampling, stop-bit check,
// and a show-ahead receive FIFO behind a valid/ready read port.
module uart_rx_fifo #(
    parameter int clk_freq   = 50_000_000,
    parameter int baud_ratio = 115200,
    parameter int depth      = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rxd,
    output logic [7:0]              rdata,
    output logic                    rvld,
    input  logic                    rrdy,
    output logic [$clog2(depth):0]  count,
    output logic                    busy,
    output logic                    frame_err,
    output logic                    overrun
);

    localparam int DIV  = clk_freq / baud_ratio;
    localparam int HALF = DIV / 2;
    localparam int PW   = $clog2(depth);
    localparam int CW   = $clog2(DIV) + 1;
    localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_END  = CW'(DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    logic          rx_meta_q, rxs_q, rxs_prev_q;
    state_t        state_q, state_d;
    logic [CW-1:0] bcnt_q, bcnt_d;
    logic [2:0]    bidx_q, bidx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          byte_ok, byte_bad;
    logic          frame_err_q, overrun_q;

    logic [PW:0]   wr_ptr_q, rd_ptr_q;
    logic [7:0]    mem_q [depth];
    logic          empty, full, pop, push_en, drop;

    // rxs_prev_q is only an edge-detect history bit, not a synchroniser stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
        end else begin
            rx_meta_q  <= rxd;
            rxs_q      <= rx_meta_q;
            rxs_prev_q <= rxs_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            bcnt_q      <= '0;
            bidx_q      <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bcnt_q      <= bcnt_d;
            bidx_q      <= bidx_d;
            frame_err_q <= byte_bad;
            overrun_q   <= drop;
        end
    end

    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
    end

    always_comb begin
        state_d  = state_q;
        bcnt_d   = bcnt_q + 1'b1;
        bidx_d   = bidx_q;
        shreg_d  = shreg_q;
        byte_ok  = 1'b0;
        byte_bad = 1'b0;
        case (state_q)
            S_IDLE: begin
                bcnt_d = '0;
                if (rxs_prev_q && !rxs_q) state_d = S_START;
            end
            S_START: begin
                if (bcnt_q == HALF_END) begin
                    bcnt_d  = '0;
                    bidx_d  = '0;
                    state_d = rxs_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (bcnt_q == BIT_END) begin
                    bcnt_d  = '0;
                    shreg_d = {rxs_q, shreg_q[7:1]};
                    bidx_d  = bidx_q + 1'b1;
                    if (bidx_q == 3'd7) state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bcnt_q == BIT_END) begin
                    bcnt_d = '0;
                    if (rxs_q) begin
                        byte_ok = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        byte_bad = 1'b1;
                        state_d  = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                // a break holds rxs low; only a return to idle re-arms start detection
                bcnt_d = '0;
                if (rxs_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != S_IDLE);
        frame_err = frame_err_q;
        overrun   = overrun_q;
    end

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign pop     = !empty && rrdy;
    // a pop in the same cycle frees the slot the push needs
    assign push_en = byte_ok && (!full || pop);
    assign drop    = byte_ok && full && !pop;

    always_ff @(posedge clk) begin
        if (push_en) mem_q[wr_ptr_q[PW-1:0]] <= shreg_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    assign rvld  = !empty;
    assign rdata = empty ? 8'h00 : mem_q[rd_ptr_q[PW-1:0]];
    assign count = wr_ptr_q - rd_ptr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised bench for uart_rx_fifo: drives 8N1 frames and compares against
// a queue-based model of the receive FIFO and pulse counts.
module tb_uart_rx_fifo;

    localparam int CLK_F = 1_700_000;
    localparam int BAUD  = 100_000;
    localparam int DEPTH = 8;
    localparam int DIV   = CLK_F / BAUD;
    localparam int HALF  = DIV / 2;
    localparam int CNTW  = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            rxd = 1'b1;
    logic            rrdy = 1'b0;
    logic [7:0]      rdata;
    logic            rvld;
    logic [CNTW-1:0] count;
    logic            busy;
    logic            frame_err;
    logic            overrun;

    int n_chk = 0;
    int n_err = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    int exp_ferr = 0;
    int exp_ovr = 0;
    logic [7:0] exp_q[$];
    logic [7:0] burst [5] = '{8'h68, 8'h65, 8'h6C, 8'h70, 8'h0A};

    uart_rx_fifo #(
        .clk_freq   (CLK_F),
        .baud_ratio (BAUD),
        .depth      (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rxd       (rxd),
        .rdata     (rdata),
        .rvld      (rvld),
        .rrdy      (rrdy),
        .count     (count),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_err) ferr_cnt++;
        if (overrun)   ovr_cnt++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // call just after a rising edge; each bit is held for DIV clocks
    task automatic send_frame(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        repeat (DIV) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (DIV) @(posedge clk);
            #1;
        end
        rxd = stop;
        repeat (DIV) @(posedge clk);
        #1;
    endtask

    task automatic model_frame(input logic [7:0] b, input logic stop);
        if (!stop)                    exp_ferr++;
        else if (exp_q.size() < DEPTH) exp_q.push_back(b);
        else                          exp_ovr++;
    endtask

    task automatic pop_chk();
        chk("pop_rvld", rvld, 1);
        chk("pop_rdata", rdata, exp_q[0]);
        rrdy = 1'b1;
        @(posedge clk);
        #1;
        rrdy = 1'b0;
        void'(exp_q.pop_front());
        chk("pop_count", count, exp_q.size());
    endtask

    task automatic chk_status(input string tag);
        chk({tag, "_count"}, count, exp_q.size());
        chk({tag, "_ferr"}, ferr_cnt, exp_ferr);
        chk({tag, "_ovr"}, ovr_cnt, exp_ovr);
    endtask

    initial begin
        logic [7:0] b;
        logic       stop;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_rvld", rvld, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_ovr", overrun, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single byte with exact latency of busy and rvld
        fork
            send_frame(8'h55, 1'b1);
            begin
                repeat (2) @(posedge clk);
                #1;
                chk("busy_before_t0", busy, 0);
                @(posedge clk);
                #1;
                chk("busy_after_t0", busy, 1);
                repeat (HALF + 9 * DIV - 1) @(posedge clk);
                #1;
                chk("rvld_early", rvld, 0);
                @(posedge clk);
                #1;
                chk("rvld_on_time", rvld, 1);
                chk("rdata_55", rdata, 8'h55);
                chk("count_1", count, 1);
                chk("busy_done", busy, 0);
            end
        join
        model_frame(8'h55, 1'b1);
        pop_chk();
        chk("rvld_after_pop", rvld, 0);

        rrdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rrdy = 1'b0;
        chk("empty_pop_count", count, 0);
        chk("empty_pop_rvld", rvld, 0);

        foreach (burst[i]) begin
            send_frame(burst[i], 1'b1);
            model_frame(burst[i], 1'b1);
        end
        chk_status("burst");
        while (exp_q.size() > 0) pop_chk();

        // nine bytes into an eight-entry FIFO
        for (int i = 0; i < 9; i++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1);
            model_frame(b, 1'b1);
        end
        chk_status("overrun");
        while (exp_q.size() > 0) pop_chk();

        // ninth byte lands while a pop frees the head in the push cycle
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1);
            model_frame(b, 1'b1);
        end
        b = 8'($urandom);
        fork
            send_frame(b, 1'b1);
            begin
                repeat (2 + HALF + 9 * DIV) @(posedge clk);
                #1;
                rrdy = 1'b1;
                @(posedge clk);
                #1;
                rrdy = 1'b0;
            end
        join
        void'(exp_q.pop_front());
        exp_q.push_back(b);
        chk_status("full_pushpop");
        while (exp_q.size() > 0) pop_chk();

        // framing error followed by a long break, then a good byte
        send_frame(8'hA5, 1'b0);
        model_frame(8'hA5, 1'b0);
        repeat (10 * DIV) @(posedge clk);
        #1;
        chk("break_busy", busy, 1);
        chk_status("break_mid");
        repeat (10 * DIV) @(posedge clk);
        #1;
        rxd = 1'b1;
        repeat (2 * DIV) @(posedge clk);
        #1;
        chk("break_end_busy", busy, 0);
        send_frame(8'h3C, 1'b1);
        model_frame(8'h3C, 1'b1);
        chk_status("after_break");
        pop_chk();

        // short low glitch rejected at the start-bit sample
        fork
            begin
                rxd = 1'b0;
                repeat (HALF / 2) @(posedge clk);
                #1;
                rxd = 1'b1;
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                chk("glitch_busy", busy, 1);
                repeat (HALF) @(posedge clk);
                #1;
                chk("glitch_rejected", busy, 0);
            end
        join
        repeat (DIV) @(posedge clk);
        #1;
        chk_status("glitch");

        for (int i = 0; i < 14; i++) begin
            b = 8'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            send_frame(b, stop);
            if (!stop) begin
                rxd = 1'b1;
                repeat (DIV) @(posedge clk);
                #1;
            end
            model_frame(b, stop);
            chk_status("rand");
            if ($urandom_range(0, 2) == 0 && exp_q.size() > 0) pop_chk();
        end
        while (exp_q.size() > 0) pop_chk();

        // reset asserted during data bit 4 with three bytes queued
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1);
            model_frame(b, 1'b1);
        end
        chk("pre_reset_count", count, 3);
        fork
            send_frame(8'h96, 1'b1);
            begin
                repeat (5 * DIV + HALF) @(posedge clk);
                #2;
                rst_n = 1'b0;
                #1;
                chk("mid_rst_rvld", rvld, 0);
                chk("mid_rst_rdata", rdata, 0);
                chk("mid_rst_count", count, 0);
                chk("mid_rst_busy", busy, 0);
                chk("mid_rst_ferr", frame_err, 0);
                chk("mid_rst_ovr", overrun, 0);
            end
        join
        exp_q.delete();
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        b = 8'($urandom);
        send_frame(b, 1'b1);
        model_frame(b, 1'b1);
        chk_status("post_reset");
        pop_chk();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
